mem_stage: RTL
==============

# mem_stage

Pipeline stage 3 of the RV32I core. It consumes the execute stage's registered `stage_regs` output and performs loads and stores against the data-memory port using a read/write + `dmem_resp` handshake. It stalls upstream while an access is outstanding, then aligns and extends load data. It registers the stage bundle plus load data for writeback.

## Interface
- `width`, 32: datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in`  in  `stage_regs`  execute stage output bundle.
  - Fields used: `valid`, `alu` (effective address), `rs2` (store data), `ctrl.opcode`, `ctrl.funct3`.
  - The remaining fields pass through unchanged.
- `stall`  out  1  combinational. While high, execute must hold `in` stable.
- `dmem_read`  out  1  registered load request.
- `dmem_write`  out  1  registered store request.
- `dmem_address`  out  32  word-aligned address, `{alu[31:2],2'b00}`.
- `dmem_byte_enable`  out  4  store byte lanes.
- `dmem_wdata`  out  32  lane-shifted store data.
- `dmem_rdata`  in  32  load data, valid when `dmem_resp` is high.
- `dmem_resp`  in  1  single-cycle completion pulse.
- `regs`  out  `stage_regs`  registered bundle to writeback.
- `rdata`  out  32  registered, aligned and extended load result.
- `misaligned`  out  1  registered. High for one output slot when the access was suppressed.

## Operation
- Definitions:
  - `mem_op = in.valid && (ctrl.opcode==op_load || op_store)`.
  - `off = in.alu[1:0]`.
- Misalignment:
  - Half access (funct3 LH/LHU/SH) with `off==3` is misaligned.
  - Word access (LW/SW) with `off!=0` is misaligned.
  - A misaligned op issues no dmem request and passes through with `misaligned=1` and `rdata=0`.
- Store lanes:
  - SB: `be = 0001<<off`, `wdata = rs2[7:0]` replicated or shifted to lane `off`.
  - SH: `be = 0011<<off`, data shifted by `off*8`.
  - SW: `be = 1111`, `wdata = rs2`.
- Load extraction: byte or half is taken from `dmem_rdata >> (off*8)`.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- FSM states: IDLE and ACCESS.
  - IDLE with an aligned `mem_op`: `stall=1`. Latch address, byte enables, wdata, read/write and the offset/funct3 needed for extraction. Go to ACCESS. `regs` loads a bubble (`valid=0`).
  - IDLE otherwise: `stall=0`. `regs<=in`, `rdata<=0`, `misaligned<=` the misalignment flag.
  - ACCESS with `dmem_resp=0`: `stall=1`. Request held stable. `regs` loads a bubble.
  - ACCESS with `dmem_resp=1`: `stall=0`. `regs<=in` (still held by execute). `rdata<=` extracted value. Drop the request and return to IDLE.
- The request is deasserted the cycle after `dmem_resp`. The memory must not see back-to-back requests without a low cycle.
- `dmem_resp` in IDLE is ignored.
- `dmem_byte_enable` is 0000 for loads.

## Timing
- Non-memory and invalid instructions have a 1-cycle latency with no stall.
- A memory op takes at least 2 cycles:
  - Cycle 0: detect and latch.
  - Cycle 1 onward: request is high.
  - `regs` updates at the edge ending the `dmem_resp` cycle.
- `stall` is high for cycle 0 and every ACCESS cycle without `dmem_resp`.
- Asynchronous reset, with the same state mid-ACCESS:
  - FSM goes to IDLE.
  - `dmem_read`, `dmem_write` and `dmem_byte_enable` go to 0.
  - `dmem_address`, `dmem_wdata`, `rdata`, `misaligned` and all `regs` fields go to 0, including `regs.valid=0`.
  - An outstanding request is abandoned, and a later `dmem_resp` in IDLE is ignored.
- Stall is never asserted for `valid=0` inputs, even if the opcode encodes a load or store.

## Test plan
- ALU op passthrough: `valid=1`, opcode op_reg, `alu=0x1234` → next cycle `regs.alu=0x1234`, `regs.valid=1`, `stall` never high, no dmem request.
- LB sign-extend: `alu=0x103`, `dmem_rdata=0x80FF_FF7F`, resp on the 3rd request cycle.
  - Address is 0x100, `stall` is high for 3 cycles.
  - Then `rdata=0xFFFF_FF80` and `regs.valid=1` exactly once.
- SH at `off=2`: `rs2=0xABCD_1234`, `alu=0x202` → `be=1100`, `wdata[31:16]=0x1234`, `dmem_write=1` until resp, then low.
- Misaligned LW: `alu=0x101` → no dmem_read, `stall=0`, `misaligned=1`, `rdata=0`.
- Reset mid-ACCESS: drop `rst_n` while `dmem_read=1` → all outputs 0 immediately. A following `dmem_resp` produces no `regs.valid`.
- Back-to-back loads with immediate resp:
  - Each load takes 2 cycles.
  - `dmem_read` shows a low cycle between the two requests.
  - Two `valid` writebacks appear with the correct data.

Source files
------------

// File: rtl/mem_stage.sv
//==============================================================================
// Module   : mem_stage
// Purpose  : RV32I stage 3 - data-memory load/store with resp handshake,
//            load alignment/extension and writeback register bundle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32i_pkg;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } stage_regs;
endpackage

module mem_stage
    import rv32i_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  stage_regs        in,
    output logic             stall,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [width-1:0] dmem_address,
    output logic [3:0]       dmem_byte_enable,
    output logic [width-1:0] dmem_wdata,
    input  logic [width-1:0] dmem_rdata,
    input  logic             dmem_resp,
    output stage_regs        regs,
    output logic [width-1:0] rdata,
    output logic             misaligned
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_issue;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;

    assign w_is_load  = (in.ctrl.opcode == c_OP_LOAD);
    assign w_is_store = (in.ctrl.opcode == c_OP_STORE);
    assign w_mem_op   = in.valid && (w_is_load || w_is_store);
    assign w_off      = in.alu[1:0];

    // funct3[1:0] selects size for both loads and stores: 00 byte, 01 half, 10 word
    always_comb begin
        w_misaligned = 1'b0;
        case (in.ctrl.funct3[1:0])
            2'b01:   w_misaligned = (w_off == 2'd3);
            2'b10:   w_misaligned = (w_off != 2'd0);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_issue = w_mem_op && !w_misaligned;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        if (w_is_store) begin
            case (in.ctrl.funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {24'h0, in.rs2[7:0]} << {w_off, 3'b000};
                end
                2'b01: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {16'h0, in.rs2[15:0]} << {w_off, 3'b000};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = in.rs2;
                end
            endcase
        end
    end

    assign w_shifted = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_val = w_shifted;
        case (r_funct3)
            c_F3_LB:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_F3_LH:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_F3_LW:  w_load_val = w_shifted;
            c_F3_LBU: w_load_val = {24'h0, w_shifted[7:0]};
            c_F3_LHU: w_load_val = {16'h0, w_shifted[15:0]};
            default:  w_load_val = w_shifted;
        endcase
    end

    assign stall = (r_state == ST_IDLE) ? w_issue : !dmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_off            <= 2'd0;
            r_funct3         <= 3'd0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_byte_enable <= 4'b0000;
            dmem_wdata       <= '0;
            regs             <= '0;
            rdata            <= '0;
            misaligned       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state          <= ST_ACCESS;
                        r_off            <= w_off;
                        r_funct3         <= in.ctrl.funct3;
                        dmem_read        <= w_is_load;
                        dmem_write       <= w_is_store;
                        dmem_address     <= {in.alu[31:2], 2'b00};
                        dmem_byte_enable <= w_be;
                        dmem_wdata       <= w_wdata;
                        regs             <= '0;
                        rdata            <= '0;
                        misaligned       <= 1'b0;
                    end else begin
                        regs       <= in;
                        rdata      <= '0;
                        misaligned <= w_mem_op && w_misaligned;
                    end
                end
                ST_ACCESS: begin
                    misaligned <= 1'b0;
                    if (dmem_resp) begin
                        r_state          <= ST_IDLE;
                        dmem_read        <= 1'b0;
                        dmem_write       <= 1'b0;
                        dmem_byte_enable <= 4'b0000;
                        regs             <= in;
                        // dmem_read is still high here only for loads
                        rdata            <= dmem_read ? w_load_val : 32'h0;
                    end else begin
                        regs  <= '0;
                        rdata <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
